imsic_msi_tx: RTL
=================

Name: imsic_msi_tx

Overview:
Bus-side MSI transmitter for the IMSIC.
- Accepts MSI writes (target hart, interrupt file, interrupt identity) from the bus slave front end.
- Drops illegal writes and buffers legal ones in a small FIFO.
- Serialises buffered writes onto the msi_info / msi_info_vld level handshake consumed by the per-hart CSR-side receiver.
- The receiver synchronises vld and captures info on the falling edge of synchronised vld. This block guarantees vld pulse width and info hold time for that capture.

Parameters:
- NR_INTP_FILES, 7, interrupt files per hart (m, s, vs...).
- NR_HARTS, 4, harts per group.
- NR_HARTS_WIDTH, 2, hart ID width.
- NR_SRC, 32, interrupt identities per file; identity 0 is reserved.
- MSI_INFO_WIDTH, 17, info bus width; must be >= NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH.
- FIFO_DEPTH, 4, buffered MSIs; power of two, >= 2.
- VLD_HIGH_CYC, 4, cycles o_msi_info_vld is held high; >= 1.
- VLD_LOW_CYC, 6, cycles info is held after vld falls; must be >= receiver EID_VLD_DLY + 4.
- NR_SRC_WIDTH, $clog2(NR_SRC), derived.
- INTP_FILE_WIDTH, $clog2(NR_INTP_FILES), derived.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- i_wr_vld  input  1  MSI write request.
- o_wr_rdy  output  1  write accepted when i_wr_vld & o_wr_rdy.
- i_wr_hart  input  NR_HARTS_WIDTH  target hart.
- i_wr_file  input  INTP_FILE_WIDTH  target interrupt file (0 = m, 1 = s, 2+ = vs).
- i_wr_data  input  32  interrupt identity (setipnum).
- o_msi_info  output  MSI_INFO_WIDTH  packed MSI info to receivers.
- o_msi_info_vld  output  1  handshake level to receivers.
- o_busy  output  1  FSM not IDLE or FIFO non-empty.
- o_drop_cnt  output  16  dropped-write count (only with the optional feature).

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rstn. All state clears immediately on rstn low.
- Reset values: o_msi_info = 0, o_msi_info_vld = 0, o_busy = 0, o_drop_cnt = 0, FIFO empty, FSM in IDLE.
- o_wr_rdy = !fifo_full. It is 1 out of reset.
- Legality check, evaluated on the accept cycle:
  - i_wr_data != 0 and i_wr_data < NR_SRC (full 32-bit compare).
  - i_wr_file < NR_INTP_FILES.
  - i_wr_hart < NR_HARTS.
  - When NR_HARTS = 1, the hart check is skipped and the hart field is driven 0.
- Illegal accepted writes are consumed and discarded; no push.
- Legal accepted writes push {hart, file, data[NR_SRC_WIDTH-1:0]} into the FIFO.
- Packing of o_msi_info:
  - [MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH] = hart.
  - [NR_SRC_WIDTH+INTP_FILE_WIDTH-1 : NR_SRC_WIDTH] = file.
  - [NR_SRC_WIDTH-1:0] = setipnum.
  - All other bits are 0.
- FSM states: IDLE, HIGH, LOW. A down-counter holds the phase length.
  - IDLE with FIFO non-empty: pop the head. At the next edge, load o_msi_info, set o_msi_info_vld = 1, go to HIGH with count = VLD_HIGH_CYC.
  - HIGH: o_msi_info_vld stays high for exactly VLD_HIGH_CYC cycles. Then o_msi_info_vld = 0 and go to LOW with count = VLD_LOW_CYC.
  - LOW: o_msi_info stays stable for exactly VLD_LOW_CYC cycles, then go to IDLE.
  - o_msi_info changes only on a load out of IDLE.
- Latency: an accept at edge t (FIFO previously empty) raises vld at edge t+2. No bypass path.
- Minimum spacing between vld rising edges is VLD_HIGH_CYC + VLD_LOW_CYC + 1 cycles (11 at defaults).
- FIFO order is strict; there is no coalescing of duplicate MSIs.
- A push and a pop in the same cycle are both honoured, and occupancy is unchanged.
- A push is impossible when full (rdy = 0).
- Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- Reset mid-operation: vld drops asynchronously, all queued MSIs are lost, and nothing is emitted until a new write arrives.

Optional Feature:
- Macro IMSIC_MSI_TX_DROP_CNT_EN.
- Defined: o_drop_cnt increments by 1 for each accepted illegal write and saturates at 0xFFFF.
- Undefined: the o_drop_cnt port and its counter are absent; illegal writes are still silently dropped.

Test Plan:
- Reset with i_wr_vld = 0 -> o_msi_info = 0, vld = 0, busy = 0, o_wr_rdy = 1; async assertion mid-cycle clears vld at once.
- Legal write hart = 2, file = 1, data = 5 at edge t:
  - vld rises at t+2 with o_msi_info = 0x10025.
  - vld is high 4 cycles, then low, with info held 6 more cycles.
  - busy falls after that.
- Illegal writes data = 0, data = 32, file = 7 -> all accepted (rdy = 1), vld never rises, o_drop_cnt = 3 (macro on).
- Six back-to-back legal writes, data = 1..6, FIFO_DEPTH = 4:
  - o_wr_rdy drops while 4 entries are held.
  - All six are emitted in order 1..6.
  - vld rising edges are exactly 11 cycles apart.
- Push in the same cycle the FSM pops (occupancy 2) -> occupancy stays 2 and no entry is lost or duplicated.
- rstn asserted during HIGH with 3 queued -> vld drops immediately; after release no MSI is emitted and busy = 0.

Source files
------------

// File: rtl/imsic_msi_tx_if.sv
// MSI write request channel from the bus slave front end into imsic_msi_tx.
// master = bus front end, slave = MSI transmitter.
interface imsic_msi_tx_if #(
  parameter int NR_HARTS_WIDTH  = 2,
  parameter int INTP_FILE_WIDTH = 3
);
  logic                       i_wr_vld;
  logic                       o_wr_rdy;
  logic [NR_HARTS_WIDTH-1:0]  i_wr_hart;
  logic [INTP_FILE_WIDTH-1:0] i_wr_file;
  logic [31:0]                i_wr_data;

  modport master (output i_wr_vld, i_wr_hart, i_wr_file, i_wr_data, input  o_wr_rdy);
  modport slave  (input  i_wr_vld, i_wr_hart, i_wr_file, i_wr_data, output o_wr_rdy);
endinterface

// File: rtl/imsic_msi_tx.sv
// IMSIC bus-side MSI transmitter: legality filter, FIFO, and vld/info level handshake.
// Optional dropped-write counter enabled by defining IMSIC_MSI_TX_DROP_CNT_EN.
module imsic_msi_tx #(
  parameter int NR_INTP_FILES   = 7,
  parameter int NR_HARTS        = 4,
  parameter int NR_HARTS_WIDTH  = 2,
  parameter int NR_SRC          = 32,
  parameter int MSI_INFO_WIDTH  = 17,
  parameter int FIFO_DEPTH      = 4,
  parameter int VLD_HIGH_CYC    = 4,
  parameter int VLD_LOW_CYC     = 6,
  parameter int NR_SRC_WIDTH    = $clog2(NR_SRC),
  parameter int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES)
) (
  input  logic                      clk,
  input  logic                      rstn,
  imsic_msi_tx_if.slave             wr,
  output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
  output logic                      o_msi_info_vld,
  output logic                      o_busy
`ifdef IMSIC_MSI_TX_DROP_CNT_EN
  ,
  output logic [15:0]               o_drop_cnt
`endif
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PTR_W   = AW + 1;
  localparam int CNT_MAX = (VLD_HIGH_CYC > VLD_LOW_CYC) ? VLD_HIGH_CYC : VLD_LOW_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [INTP_FILE_WIDTH:0] FILE_LIM = (INTP_FILE_WIDTH + 1)'(NR_INTP_FILES);
  localparam logic [NR_HARTS_WIDTH:0]  HART_LIM = (NR_HARTS_WIDTH + 1)'(NR_HARTS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  typedef struct packed {
    logic [NR_HARTS_WIDTH-1:0]  hart;
    logic [INTP_FILE_WIDTH-1:0] file;
    logic [NR_SRC_WIDTH-1:0]    src;
  } entry_t;

  // Legality check on the accept cycle; full 32-bit compare on the identity.
  logic   src_ok, file_ok, hart_ok, legal, accept, push, pop;
  entry_t push_entry, head;

  assign src_ok  = (wr.i_wr_data != '0) && (wr.i_wr_data < 32'(NR_SRC));
  assign file_ok = {1'b0, wr.i_wr_file} < FILE_LIM;
  assign hart_ok = (NR_HARTS == 1) || ({1'b0, wr.i_wr_hart} < HART_LIM);
  assign legal   = src_ok && file_ok && hart_ok;
  assign accept  = wr.i_wr_vld && wr.o_wr_rdy;
  assign push    = accept && legal;

  assign push_entry.hart = (NR_HARTS == 1) ? '0 : wr.i_wr_hart;
  assign push_entry.file = wr.i_wr_file;
  assign push_entry.src  = wr.i_wr_data[NR_SRC_WIDTH-1:0];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full;
  logic             avail_q;
  entry_t           mem_q [FIFO_DEPTH];

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr.o_wr_rdy = !fifo_full;
  assign head        = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      avail_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // Registered non-empty gives a fresh entry one cycle before it may be popped.
      avail_q <= !fifo_empty;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MSI_INFO_WIDTH-1:0] info_q, info_d;
  logic                      vld_q, vld_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      info_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      info_q  <= info_d;
      vld_q   <= vld_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    info_d  = info_q;
    vld_d   = vld_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail_q && !fifo_empty) begin
          pop    = 1'b1;
          info_d = '0;
          info_d[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH] = head.hart;
          info_d[NR_SRC_WIDTH +: INTP_FILE_WIDTH]    = head.file;
          info_d[NR_SRC_WIDTH-1:0]                   = head.src;
          vld_d   = 1'b1;
          cnt_d   = CNT_W'(VLD_HIGH_CYC);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == CNT_W'(1)) begin
          vld_d   = 1'b0;
          cnt_d   = CNT_W'(VLD_LOW_CYC);
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        // info stays frozen here so the receiver can capture on its delayed falling edge
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_msi_info     = info_q;
  assign o_msi_info_vld = vld_q;
  assign o_busy         = (state_q != IDLE) || !fifo_empty;

`ifdef IMSIC_MSI_TX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       drop_cnt_q <= '0;
    else if (accept && !legal && drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  // Without the counter, illegal writes are consumed and silently discarded.
`endif

endmodule
